// File: rtl/sram_wordline_ctrl.sv
// Row decode + word-line sequencer: latch row, pulse one word line, precharge, signal done.
// Latency: accept to done = 1 + PULSE_CYC + PRECH_CYC cycles; one access per 2 + PULSE_CYC + PRECH_CYC.
// Backpressure: ready is high only in IDLE; req is ignored unless ready and enbl are both high.
module sram_wordline_ctrl #(
  parameter int ADDR_W    = 5,
  parameter int ROWS      = 32,
  parameter int PULSE_CYC = 2,
  parameter int PRECH_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enbl,
  input  logic              req,
  input  logic [ADDR_W-1:0] a,
  output logic              ready,
  output logic [ROWS-1:0]   d,
  output logic              prech,
  output logic              done,
  output logic              err
);

  localparam int MAX_CYC = (PULSE_CYC > PRECH_CYC) ? PULSE_CYC : PRECH_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] PRECH_LD = CNT_W'(PRECH_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_ACTIVE = 2'd2,
    S_PRECH  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROWS-1:0]   d_q, d_d;
  logic              prech_q, prech_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [ROWS-1:0]   row_dec;
  logic              in_range;

  // One-hot decode of the latched row; addresses beyond ROWS decode to all-zero.
  always_comb begin
    row_dec  = '0;
    in_range = (32'(addr_q) < 32'(ROWS));
    for (int i = 0; i < ROWS; i++) begin
      row_dec[i] = (32'(addr_q) == 32'(i));
    end
  end

  // Next-state and registered-output logic; abort takes priority over decode/pulse timing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    d_d     = d_q;
    prech_d = prech_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req && enbl) begin
          addr_d  = a;
          err_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!enbl) begin
          state_d = S_PRECH;
          d_d     = '0;
          prech_d = 1'b1;
          err_d   = 1'b1;
          cnt_d   = PRECH_LD;
        end else begin
          // Out-of-range rows still walk the full timing so callers see fixed latency.
          state_d = S_ACTIVE;
          cnt_d   = PULSE_LD;
          d_d     = row_dec;
          if (!in_range) begin
            err_d = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (!enbl || (cnt_q == '0)) begin
          state_d = S_PRECH;
          d_d     = '0;
          prech_d = 1'b1;
          cnt_d   = PRECH_LD;
          if (!enbl) begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PRECH: begin
        // Precharge always runs to completion, regardless of enbl.
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          prech_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        d_d     = '0;
        prech_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; async reset drops word lines and precharge immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      d_q     <= '0;
      prech_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      d_q     <= d_d;
      prech_q <= prech_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign d     = d_q;
  assign prech = prech_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_sram_wordline_ctrl.sv
// Bench for sram_wordline_ctrl: three instances cover default, reduced ROWS and long timing.
// Per-cycle expected outputs are derived from the accept edge; a scoreboard holds per-access results.
// Input stimulus has no backpressure of its own; it follows the DUT ready.
module tb_sram_wordline_ctrl;

  localparam int P0 = 2;
  localparam int Q0 = 1;
  localparam int P2 = 4;
  localparam int Q2 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        enbl0, req0, ready0, prech0, done0, err0;
  logic [4:0]  a0;
  logic [31:0] d0;
  logic        enbl1, req1, ready1, prech1, done1, err1;
  logic [4:0]  a1;
  logic [23:0] d1;
  logic        enbl2, req2, ready2, prech2, done2, err2;
  logic [2:0]  a2;
  logic [7:0]  d2;

  sram_wordline_ctrl u_dut0 (
    .clk(clk), .rst(rst), .enbl(enbl0), .req(req0), .a(a0),
    .ready(ready0), .d(d0), .prech(prech0), .done(done0), .err(err0)
  );

  sram_wordline_ctrl #(.ADDR_W(5), .ROWS(24), .PULSE_CYC(2), .PRECH_CYC(1)) u_dut1 (
    .clk(clk), .rst(rst), .enbl(enbl1), .req(req1), .a(a1),
    .ready(ready1), .d(d1), .prech(prech1), .done(done1), .err(err1)
  );

  sram_wordline_ctrl #(.ADDR_W(3), .ROWS(8), .PULSE_CYC(P2), .PRECH_CYC(Q2)) u_dut2 (
    .clk(clk), .rst(rst), .enbl(enbl2), .req(req2), .a(a2),
    .ready(ready2), .d(d2), .prech(prech2), .done(done2), .err(err2)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enbl0 = 1'b0; req0 = 1'b0; a0 = '0;
    enbl1 = 1'b0; req1 = 1'b0; a1 = '0;
    enbl2 = 1'b0; req2 = 1'b0; a2 = '0;
    #12;
    checks++;
    if ({ready0, d0, prech0, done0, err0} !== {1'b1, 32'h0, 3'b000}) begin
      failures++;
      $display("FAIL reset0 ready=%b d=%h prech=%b done=%b err=%b, want ready=1 rest 0",
               ready0, d0, prech0, done0, err0);
    end
    checks++;
    if ({ready2, d2, prech2, done2, err2} !== {1'b1, 8'h0, 3'b000}) begin
      failures++;
      $display("FAIL reset2 ready=%b d=%h prech=%b done=%b err=%b, want ready=1 rest 0",
               ready2, d2, prech2, done2, err2);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    exp_t e;
    logic [31:0] cap, exp_d;
    logic exp_p, exp_dn;
    enbl0 = 1'b1; a0 = 5'd9; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    sb.push_back('{d: 32'h0000_0200, err: 1'b0});
    checks++;
    if (ready0 !== 1'b0 || d0 !== 32'h0) begin
      failures++;
      $display("FAIL single_decode ready=%b d=%h, want ready=0 d=0", ready0, d0);
    end
    cap = '0;
    for (int k = 1; k <= 1 + P0 + Q0; k++) begin
      tick();
      exp_d  = (k <= P0) ? 32'h0000_0200 : 32'h0;
      exp_p  = (k > P0) && (k <= P0 + Q0);
      exp_dn = (k == 1 + P0 + Q0);
      if (k == 1) cap = d0;
      checks++;
      if ({d0, prech0, done0, ready0} !== {exp_d, exp_p, exp_dn, exp_dn}) begin
        failures++;
        $display("FAIL single_cyc%0d d=%h prech=%b done=%b ready=%b, want d=%h prech=%b done=%b ready=%b",
                 k, d0, prech0, done0, ready0, exp_d, exp_p, exp_dn, exp_dn);
      end
    end
    e = sb.pop_front();
    checks++;
    if (cap !== e.d || err0 !== e.err) begin
      failures++;
      $display("FAIL single_sb d=%h err=%b, want d=%h err=%b", cap, err0, e.d, e.err);
    end
    tick();
    checks++;
    if (done0 !== 1'b0 || ready0 !== 1'b1) begin
      failures++;
      $display("FAIL single_done_width done=%b ready=%b, want done=0 ready=1", done0, ready0);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [31:0] cap, exp_d;
    logic exp_p, exp_dn;
    req0 = 1'b1;
    for (int r = 0; r < 32; r++) begin
      a0 = 5'(r);
      sb.push_back('{d: (32'd1 << r), err: 1'b0});
      checks++;
      if (ready0 !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready row=%0d ready=%b, want 1", r, ready0);
      end
      tick();
      cap = '0;
      for (int k = 1; k <= 1 + P0 + Q0; k++) begin
        tick();
        exp_d  = (k <= P0) ? (32'd1 << r) : 32'h0;
        exp_p  = (k > P0) && (k <= P0 + Q0);
        exp_dn = (k == 1 + P0 + Q0);
        if (k == 1) cap = d0;
        checks++;
        if ({d0, prech0, done0} !== {exp_d, exp_p, exp_dn} || (d0 != 32'h0 && prech0)) begin
          failures++;
          $display("FAIL b2b row=%0d cyc=%0d d=%h prech=%b done=%b, want d=%h prech=%b done=%b",
                   r, k, d0, prech0, done0, exp_d, exp_p, exp_dn);
        end
      end
      e = sb.pop_front();
      checks++;
      if (cap !== e.d || err0 !== e.err) begin
        failures++;
        $display("FAIL b2b_sb row=%0d d=%h err=%b, want d=%h err=%b", r, cap, err0, e.d, e.err);
      end
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (done0 !== 1'b0 || ready0 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end done=%b ready=%b, want done=0 ready=1", done0, ready0);
    end
  endtask

  task automatic test_abort;
    exp_t e;
    a0 = 5'd17; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    sb.push_back('{d: 32'h0, err: 1'b1});
    tick();
    checks++;
    if (d0 !== 32'h0002_0000) begin
      failures++;
      $display("FAIL abort_active d=%h, want 00020000", d0);
    end
    enbl0 = 1'b0;
    tick();
    checks++;
    if ({d0, prech0, done0, err0} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL abort_prech d=%h prech=%b done=%b err=%b, want d=0 prech=1 done=0 err=1",
               d0, prech0, done0, err0);
    end
    tick();
    e = sb.pop_front();
    checks++;
    if ({d0, prech0, done0, ready0, err0} !== {e.d, 1'b0, 1'b1, 1'b1, e.err}) begin
      failures++;
      $display("FAIL abort_done d=%h prech=%b done=%b ready=%b err=%b, want d=0 prech=0 done=1 ready=1 err=%b",
               d0, prech0, done0, ready0, err0, e.err);
    end
    enbl0 = 1'b1;
    tick();
  endtask

  task automatic test_async_reset;
    enbl0 = 1'b1; a0 = 5'd12; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    checks++;
    if (d0 !== 32'h0000_1000) begin
      failures++;
      $display("FAIL arst_pre d=%h, want 00001000", d0);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({d0, prech0, ready0} !== {32'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL arst_async d=%h prech=%b ready=%b, want d=0 prech=0 ready=1", d0, prech0, ready0);
    end
    #2 rst = 1'b0;
    tick();
    req0 = 1'b1; enbl0 = 1'b0; a0 = 5'd4;
    tick();
    checks++;
    if (ready0 !== 1'b1 || d0 !== 32'h0) begin
      failures++;
      $display("FAIL ignore_req ready=%b d=%h, want ready=1 d=0", ready0, d0);
    end
    tick();
    checks++;
    if ({ready0, done0, prech0, d0} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL ignore_req2 ready=%b done=%b prech=%b d=%h, want ready=1 others 0",
               ready0, done0, prech0, d0);
    end
    req0 = 1'b0; enbl0 = 1'b1;
  endtask

  task automatic test_out_of_range;
    exp_t e;
    logic [23:0] cap, exp_d;
    logic exp_p, exp_dn;
    enbl1 = 1'b1; a1 = 5'd27; req1 = 1'b1;
    tick();
    req1 = 1'b0;
    sb.push_back('{d: 32'h0, err: 1'b1});
    cap = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_p  = (k == 3);
      exp_dn = (k == 4);
      cap = cap | d1;
      checks++;
      if ({d1, prech1, done1, err1} !== {24'h0, exp_p, exp_dn, 1'b1}) begin
        failures++;
        $display("FAIL oor_cyc%0d d=%h prech=%b done=%b err=%b, want d=0 prech=%b done=%b err=1",
                 k, d1, prech1, done1, err1, exp_p, exp_dn);
      end
    end
    e = sb.pop_front();
    checks++;
    if (32'(cap) !== e.d || err1 !== e.err) begin
      failures++;
      $display("FAIL oor_sb d=%h err=%b, want d=%h err=%b", cap, err1, e.d, e.err);
    end
    a1 = 5'd3; req1 = 1'b1;
    tick();
    req1 = 1'b0;
    sb.push_back('{d: 32'h8, err: 1'b0});
    checks++;
    if (err1 !== 1'b0) begin
      failures++;
      $display("FAIL oor_clear err=%b, want 0", err1);
    end
    cap = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_d  = (k <= 2) ? 24'h8 : 24'h0;
      exp_p  = (k == 3);
      exp_dn = (k == 4);
      if (k == 1) cap = d1;
      checks++;
      if ({d1, prech1, done1} !== {exp_d, exp_p, exp_dn}) begin
        failures++;
        $display("FAIL valid_cyc%0d d=%h prech=%b done=%b, want d=%h prech=%b done=%b",
                 k, d1, prech1, done1, exp_d, exp_p, exp_dn);
      end
    end
    e = sb.pop_front();
    checks++;
    if (32'(cap) !== e.d || err1 !== e.err) begin
      failures++;
      $display("FAIL valid_sb d=%h err=%b, want d=%h err=%b", cap, err1, e.d, e.err);
    end
  endtask

  task automatic test_long_timing;
    exp_t e;
    logic [7:0] cap, exp_d;
    logic exp_p, exp_dn;
    enbl2 = 1'b1; a2 = 3'd7; req2 = 1'b1;
    tick();
    req2 = 1'b0;
    sb.push_back('{d: 32'h80, err: 1'b0});
    cap = '0;
    for (int k = 1; k <= 1 + P2 + Q2; k++) begin
      tick();
      exp_d  = (k <= P2) ? 8'h80 : 8'h0;
      exp_p  = (k > P2) && (k <= P2 + Q2);
      exp_dn = (k == 1 + P2 + Q2);
      if (k == 1) cap = d2;
      checks++;
      if ({d2, prech2, done2, ready2} !== {exp_d, exp_p, exp_dn, exp_dn}) begin
        failures++;
        $display("FAIL long_cyc%0d d=%h prech=%b done=%b ready=%b, want d=%h prech=%b done=%b ready=%b",
                 k, d2, prech2, done2, ready2, exp_d, exp_p, exp_dn, exp_dn);
      end
    end
    e = sb.pop_front();
    checks++;
    if (32'(cap) !== e.d || err2 !== e.err) begin
      failures++;
      $display("FAIL long_sb d=%h err=%b, want d=%h err=%b", cap, err2, e.d, e.err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_out_of_range();
    test_long_timing();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_empty size=%0d, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t, want completion", $time);
    $fatal(1);
  end

endmodule
